fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/ifid_register.sv | 49 ++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared RISC-V constants for the fetch stage: instruction encodings and FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted
  } fetch_state_e;

  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == ECALL) || (instr == EBREAK);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and a combinational memory.
interface fetch_stage_if #(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32
);

  logic [INS_ADDRESS-1:0] imem_addr_o;
  logic [INS_W-1:0]       imem_data_i;

  modport master (output imem_addr_o, input imem_data_i);
  modport slave  (input imem_addr_o, output imem_data_i);

endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures, otherwise holds.
module ifid_register
  import fetch_stage_pkg::*;
#(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   load,
  input  logic [INS_W-1:0]       instr_i,
  input  logic [INS_ADDRESS-1:0] pc_i,
  input  logic [INS_ADDRESS-1:0] pc4_i,
  output logic                   valid_o,
  output logic [INS_W-1:0]       instr_o,
  output logic [INS_ADDRESS-1:0] pc_o,
  output logic [INS_ADDRESS-1:0] pc4_o
);

  logic                   valid_q;
  logic [INS_W-1:0]       instr_q;
  logic [INS_ADDRESS-1:0] pc_q;
  logic [INS_ADDRESS-1:0] pc4_q;

  // Flush leaves pc/pc4 untouched; only valid and instr define a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= INS_W'(NOP);
      pc_q    <= '0;
      pc4_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= INS_W'(NOP);
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, BOOT/RUN/HALTED control and fetch counter feeding IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [INS_ADDRESS-1:0] redirect_pc_i,
  fetch_stage_if.master          bus,
  output logic                   ifid_valid_o,
  output logic [INS_W-1:0]       ifid_instr_o,
  output logic [INS_ADDRESS-1:0] ifid_pc_o,
  output logic [INS_ADDRESS-1:0] ifid_pc4_o,
  output logic                   halted_o,
  output logic [31:0]            fetch_count_o
);

  fetch_state_e           state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]            count_q, count_d;
  logic                   flush, load;

  assign pc_plus4 = pc_q + INS_ADDRESS'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    flush   = 1'b0;
    load    = 1'b0;
    if (redirect_i) begin
      pc_d    = redirect_pc_i & ~INS_ADDRESS'(3);
      flush   = 1'b1;
      state_d = StRun;
    end else if (!stall_i) begin
      unique case (state_q)
        StBoot: begin
          flush   = 1'b1;
          state_d = StRun;
        end
        StRun: begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
          if (is_halt_instr(32'(bus.imem_data_i))) state_d = StHalted;
        end
        StHalted: flush = 1'b1;
        default:  state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= INS_ADDRESS'(RESET_PC);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr_o = pc_q;
  assign halted_o        = (state_q == StHalted);
  assign fetch_count_o   = count_q;

  ifid_register #(
    .INS_ADDRESS(INS_ADDRESS),
    .INS_W      (INS_W)
  ) u_ifid (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .load   (load),
    .instr_i(bus.imem_data_i),
    .pc_i   (pc_q),
    .pc4_i  (pc_plus4),
    .valid_o(ifid_valid_o),
    .instr_o(ifid_instr_o),
    .pc_o   (ifid_pc_o),
    .pc4_o  (ifid_pc4_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W    = 32'h0000_0013;
  localparam logic [31:0] ECALL_W  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [8:0]  redirect_pc;
  logic        ifid_valid, halted;
  logic [31:0] ifid_instr, fetch_count;
  logic [8:0]  ifid_pc, ifid_pc4;
  logic [31:0] mem [128];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;

  fetch_stage_if #(.INS_ADDRESS(9), .INS_W(32)) bus ();

  fetch_stage #(.INS_ADDRESS(9), .INS_W(32), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .bus          (bus),
    .ifid_valid_o (ifid_valid),
    .ifid_instr_o (ifid_instr),
    .ifid_pc_o    (ifid_pc),
    .ifid_pc4_o   (ifid_pc4),
    .halted_o     (halted),
    .fetch_count_o(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb bus.imem_data_i = mem[bus.imem_addr_o[8:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return ((i + 1) << 20) | ((i + 1) << 7) | 32'h13;
  endfunction

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b0, NOP_W, 9'h0, 9'h0}) begin
      $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc4=%h, want v=0 i=%h pc=0 pc4=0",
               ifid_valid, ifid_instr, ifid_pc, ifid_pc4, NOP_W);
      errors++;
    end
    checks++;
    if ({halted, fetch_count, bus.imem_addr_o} !== {1'b0, 32'd0, 9'h0}) begin
      $display("FAIL reset_ctrl: got halted=%b cnt=%0d addr=%h, want 0 0 0",
               halted, fetch_count, bus.imem_addr_o);
      errors++;
    end
    exp_cnt = 0;
  endtask

  task automatic test_free_run();
    reset = 1'b0;
    tick();
    checks++;
    if ({ifid_valid, bus.imem_addr_o} !== {1'b0, 9'h0}) begin
      $display("FAIL boot_exit: got v=%b addr=%h, want v=0 addr=000", ifid_valid, bus.imem_addr_o);
      errors++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_cnt++;
      checks++;
      if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !==
          {1'b1, mem[k], 9'(k * 4), 9'(k * 4 + 4)}) begin
        $display("FAIL run_%0d: got v=%b i=%h pc=%h pc4=%h, want v=1 i=%h pc=%h pc4=%h", k,
                 ifid_valid, ifid_instr, ifid_pc, ifid_pc4, mem[k], 9'(k * 4), 9'(k * 4 + 4));
        errors++;
      end
    end
    checks++;
    if ({fetch_count, bus.imem_addr_o} !== {32'd4, 9'h010}) begin
      $display("FAIL run_count: got cnt=%0d addr=%h, want 4 010", fetch_count, bus.imem_addr_o);
      errors++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.imem_addr_o, ifid_valid, ifid_instr, ifid_pc, fetch_count} !==
          {9'h010, 1'b1, mem[3], 9'h00c, 32'd4}) begin
        $display("FAIL stall_%0d: got addr=%h v=%b i=%h pc=%h cnt=%0d, want 010 1 %h 00c 4", k,
                 bus.imem_addr_o, ifid_valid, ifid_instr, ifid_pc, fetch_count, mem[3]);
        errors++;
      end
    end
    stall = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if ({ifid_pc, ifid_instr, bus.imem_addr_o, fetch_count} !==
        {9'h010, mem[4], 9'h014, 32'd5}) begin
      $display("FAIL stall_resume: got pc=%h i=%h addr=%h cnt=%0d, want 010 %h 014 5",
               ifid_pc, ifid_instr, bus.imem_addr_o, fetch_count, mem[4]);
      errors++;
    end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 9'h057;
    tick();
    checks++;
    if ({bus.imem_addr_o, ifid_valid, ifid_instr, fetch_count} !==
        {9'h054, 1'b0, NOP_W, 32'(exp_cnt)}) begin
      $display("FAIL stall_redirect: got addr=%h v=%b i=%h cnt=%0d, want 054 0 %h %0d",
               bus.imem_addr_o, ifid_valid, ifid_instr, fetch_count, NOP_W, exp_cnt);
      errors++;
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if ({ifid_valid, ifid_pc, ifid_instr, bus.imem_addr_o} !== {1'b1, 9'h054, mem[21], 9'h058})
    begin
      $display("FAIL redirect_fetch: got v=%b pc=%h i=%h addr=%h, want 1 054 %h 058",
               ifid_valid, ifid_pc, ifid_instr, bus.imem_addr_o, mem[21]);
      errors++;
    end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 9'h020;
    tick();
    redirect = 1'b0;
    mem[8] = ECALL_W;
    tick();
    exp_cnt++;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc, halted, bus.imem_addr_o, fetch_count} !==
        {1'b1, ECALL_W, 9'h020, 1'b1, 9'h024, 32'(exp_cnt)}) begin
      $display("FAIL ecall_capture: got v=%b i=%h pc=%h h=%b addr=%h cnt=%0d, want 1 %h 020 1 024 %0d",
               ifid_valid, ifid_instr, ifid_pc, halted, bus.imem_addr_o, fetch_count, ECALL_W,
               exp_cnt);
      errors++;
    end
    tick();
    checks++;
    if ({ifid_valid, ifid_instr, halted, bus.imem_addr_o, fetch_count} !==
        {1'b0, NOP_W, 1'b1, 9'h024, 32'(exp_cnt)}) begin
      $display("FAIL halted_hold: got v=%b i=%h h=%b addr=%h cnt=%0d, want 0 %h 1 024 %0d",
               ifid_valid, ifid_instr, halted, bus.imem_addr_o, fetch_count, NOP_W, exp_cnt);
      errors++;
    end
    mem[8] = word(8);
    redirect = 1'b1; redirect_pc = 9'h008;
    tick();
    redirect = 1'b0;
    checks++;
    if ({halted, bus.imem_addr_o, ifid_valid} !== {1'b0, 9'h008, 1'b0}) begin
      $display("FAIL halt_exit: got h=%b addr=%h v=%b, want 0 008 0",
               halted, bus.imem_addr_o, ifid_valid);
      errors++;
    end
    tick();
    exp_cnt++;
    checks++;
    if ({ifid_valid, ifid_pc, ifid_instr, fetch_count} !==
        {1'b1, 9'h008, mem[2], 32'(exp_cnt)}) begin
      $display("FAIL halt_resume: got v=%b pc=%h i=%h cnt=%0d, want 1 008 %h %0d",
               ifid_valid, ifid_pc, ifid_instr, fetch_count, mem[2], exp_cnt);
      errors++;
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 9'h1fc;
    tick();
    redirect = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if ({ifid_pc, ifid_pc4, ifid_instr, bus.imem_addr_o} !== {9'h1fc, 9'h000, mem[127], 9'h000})
    begin
      $display("FAIL wrap: got pc=%h pc4=%h i=%h addr=%h, want 1fc 000 %h 000",
               ifid_pc, ifid_pc4, ifid_instr, bus.imem_addr_o, mem[127]);
      errors++;
    end
    tick();
    exp_cnt++;
    checks++;
    if ({ifid_pc, ifid_pc4, fetch_count} !== {9'h000, 9'h004, 32'(exp_cnt)}) begin
      $display("FAIL wrap_next: got pc=%h pc4=%h cnt=%0d, want 000 004 %0d",
               ifid_pc, ifid_pc4, fetch_count, exp_cnt);
      errors++;
    end
  endtask

  task automatic test_halt_reset();
    redirect = 1'b1; redirect_pc = 9'h030;
    tick();
    redirect = 1'b0;
    mem[12] = EBREAK_W;
    tick();
    stall = 1'b1;
    tick();
    checks++;
    if ({halted, ifid_valid, ifid_instr, ifid_pc, bus.imem_addr_o} !==
        {1'b1, 1'b1, EBREAK_W, 9'h030, 9'h034}) begin
      $display("FAIL ebreak_stall: got h=%b v=%b i=%h pc=%h addr=%h, want 1 1 %h 030 034",
               halted, ifid_valid, ifid_instr, ifid_pc, bus.imem_addr_o, EBREAK_W);
      errors++;
    end
    reset = 1'b1; redirect = 1'b1; redirect_pc = 9'h100;
    tick();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4, halted, fetch_count, bus.imem_addr_o} !==
        {1'b0, NOP_W, 9'h0, 9'h0, 1'b0, 32'd0, 9'h0}) begin
      $display("FAIL halt_reset: got v=%b i=%h pc=%h pc4=%h h=%b cnt=%0d addr=%h, want 0 %h 0 0 0 0 0",
               ifid_valid, ifid_instr, ifid_pc, ifid_pc4, halted, fetch_count, bus.imem_addr_o,
               NOP_W);
      errors++;
    end
    mem[12] = word(12);
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    checks++;
    if ({ifid_valid, bus.imem_addr_o} !== {1'b0, 9'h0}) begin
      $display("FAIL post_reset_boot: got v=%b addr=%h, want 0 000", ifid_valid, bus.imem_addr_o);
      errors++;
    end
    tick();
    checks++;
    if ({ifid_valid, ifid_pc, ifid_instr, fetch_count} !== {1'b1, 9'h0, mem[0], 32'd1}) begin
      $display("FAIL post_reset_fetch: got v=%b pc=%h i=%h cnt=%0d, want 1 000 %h 1",
               ifid_valid, ifid_pc, ifid_instr, fetch_count, mem[0]);
      errors++;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = word(i);
    test_reset();
    test_free_run();
    test_stall();
    test_stall_redirect();
    test_halt();
    test_wrap();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
